// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver: holding-register handshake plus error pulses.
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;

   modport master (
      output rx_data,
      output rx_valid,
      output frame_err,
      output overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  overrun,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a one-entry
// holding register read through a valid/ready handshake.
module uart_rx #(
   parameter int Clock = 50,
   parameter int Baud  = 115200
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      rx,
   uart_rx_if.master bus
);

   localparam int DIV  = Clock * 1000000 / Baud;
   localparam int HALF = DIV / 2;
   localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic          rx_meta;
   logic          rx_s;
   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] bit_q;
   logic [CW-1:0] bit_d;
   logic [2:0]    idx_q;
   logic [2:0]    idx_d;
   logic [7:0]    shift_q;
   logic [7:0]    shift_d;
   logic          done;
   logic          bad_stop;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          ferr_q;
   logic          ovr_q;

   // Synchroniser idles high so reset never looks like a start bit by itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bit_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q + CW'(1);
      idx_d    = idx_q;
      shift_d  = shift_q;
      done     = 1'b0;
      bad_stop = 1'b0;
      case (state_q)
         IDLE: begin
            bit_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (bit_q == CW'(HALF - 1)) begin
               bit_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_q == CW'(DIV - 1)) begin
               bit_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            // Leaving at mid-stop-bit leaves half a bit of slack for the next start edge.
            if (bit_q == CW'(DIV - 1)) begin
               bit_d    = '0;
               state_d  = IDLE;
               done     = rx_s;
               bad_stop = !rx_s;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A completing byte may replace the held one only if the consumer takes it in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ferr_q <= bad_stop;
         ovr_q  <= 1'b0;
         if (done) begin
            if (!valid_q || bus.rx_ready) begin
               data_q  <= shift_q;
               valid_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (valid_q && bus.rx_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.rx_data   = data_q;
   assign bus.rx_valid  = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames driven bit by bit, holding-register
// behaviour predicted from the handshake rules.
module tb_uart_rx;

   localparam int CLOCK_MHZ = 50;
   localparam int BAUD      = 115200;
   localparam int DIV       = CLOCK_MHZ * 1000000 / BAUD;
   localparam int HALF      = DIV / 2;
   // Edges from driving the start bit to the registered result: 2 sync + HALF + 9*DIV + 1.
   localparam int LAT       = HALF + 9 * DIV + 3;

   logic clk = 1'b0;
   logic rst;
   logic rx;

   uart_rx_if bus ();

   uart_rx #(.Clock(CLOCK_MHZ), .Baud(BAUD)) dut (
      .clk (clk),
      .rst (rst),
      .rx  (rx),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         checks   = 0;
   int         failures = 0;
   logic       exp_valid;
   logic [7:0] exp_data;
   int         ferr_cnt;
   int         ovr_cnt;
   int         ferr_edge;
   int         ovr_edge;
   logic       lat_valid;
   logic [7:0] lat_data;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // mode 0: rx_ready low; 1: rx_ready high for the whole frame; 2: high only in the stop-sample cycle.
   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int mode, input int rst_at);
      ferr_cnt  = 0;
      ovr_cnt   = 0;
      ferr_edge = -1;
      ovr_edge  = -1;
      lat_valid = 1'bx;
      lat_data  = 8'hxx;
      for (int n = 0; n < 10 * DIV; n++) begin
         int pos;
         pos = n / DIV;
         if (n == rst_at) begin
            rst = 1'b1;
            rx  = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            return;
         end
         if (pos == 0)      rx = 1'b0;
         else if (pos == 9) rx = stop_bit;
         else               rx = b[3'(pos - 1)];
         if (mode == 1)      bus.rx_ready = 1'b1;
         else if (mode == 2) bus.rx_ready = (n == LAT - 1);
         @(posedge clk);
         #1;
         if (bus.frame_err === 1'b1) begin
            ferr_cnt++;
            ferr_edge = n + 1;
         end
         if (bus.overrun === 1'b1) begin
            ovr_cnt++;
            ovr_edge = n + 1;
         end
         if (n + 1 == LAT) begin
            lat_valid = bus.rx_valid;
            lat_data  = bus.rx_data;
         end
      end
      rx           = 1'b1;
      bus.rx_ready = 1'b0;
   endtask

   task automatic runFrame(input string tag, input logic [7:0] b, input logic stop_bit, input int mode);
      logic       pre_valid;
      logic       want_valid;
      logic       want_ferr;
      logic       want_ovr;
      logic [7:0] want_data;
      pre_valid  = (mode == 1) ? 1'b0 : exp_valid;
      want_valid = pre_valid;
      want_data  = exp_data;
      want_ferr  = 1'b0;
      want_ovr   = 1'b0;
      if (!stop_bit) begin
         want_ferr = 1'b1;
      end else if (!pre_valid || mode != 0) begin
         want_valid = 1'b1;
         want_data  = b;
      end else begin
         want_ovr = 1'b1;
      end
      applyStimulus(b, stop_bit, mode, -1);
      checkOutput({tag, "_valid_at_done"}, 32'(lat_valid), 32'(want_valid));
      checkOutput({tag, "_data_at_done"}, 32'(lat_data), 32'(want_data));
      checkOutput({tag, "_ferr_pulses"}, ferr_cnt, 32'(want_ferr));
      checkOutput({tag, "_ovr_pulses"}, ovr_cnt, 32'(want_ovr));
      if (want_ferr) checkOutput({tag, "_ferr_time"}, ferr_edge, LAT);
      if (want_ovr)  checkOutput({tag, "_ovr_time"}, ovr_edge, LAT);
      exp_valid = (mode == 1) ? 1'b0 : want_valid;
      exp_data  = want_data;
      checkOutput({tag, "_valid_end"}, 32'(bus.rx_valid), 32'(exp_valid));
      checkOutput({tag, "_data_end"}, 32'(bus.rx_data), 32'(exp_data));
   endtask

   task automatic consume(input string tag);
      checkOutput({tag, "_valid_before_take"}, 32'(bus.rx_valid), 32'(exp_valid));
      bus.rx_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_ready = 1'b0;
      exp_valid    = 1'b0;
      checkOutput({tag, "_valid_after_take"}, 32'(bus.rx_valid), 32'(exp_valid));
      checkOutput({tag, "_data_after_take"}, 32'(bus.rx_data), 32'(exp_data));
   endtask

   initial begin
      int seen;
      rst          = 1'b1;
      rx           = 1'b1;
      bus.rx_ready = 1'b0;
      exp_valid    = 1'b0;
      exp_data     = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset_valid", 32'(bus.rx_valid), 32'd0);
      checkOutput("reset_data", 32'(bus.rx_data), 32'd0);
      checkOutput("reset_ferr", 32'(bus.frame_err), 32'd0);
      checkOutput("reset_ovr", 32'(bus.overrun), 32'd0);

      runFrame("single_55", 8'h55, 1'b1, 0);
      consume("single_55");

      runFrame("b2b_A3", 8'hA3, 1'b1, 1);
      runFrame("b2b_0F", 8'h0F, 1'b1, 1);

      runFrame("ovr_first_12", 8'h12, 1'b1, 0);
      runFrame("ovr_drop_34", 8'h34, 1'b1, 0);
      runFrame("same_cycle_56", 8'h56, 1'b1, 2);

      runFrame("ferr_FF", 8'hFF, 1'b0, 0);
      consume("after_ferr");
      runFrame("after_ferr_81", 8'h81, 1'b1, 0);

      seen = 0;
      rx   = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      rx = 1'b1;
      for (int i = 0; i < DIV; i++) begin
         @(posedge clk);
         #1;
         if (bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) seen++;
      end
      checkOutput("glitch_pulses", seen, 32'd0);
      checkOutput("glitch_valid", 32'(bus.rx_valid), 32'(exp_valid));
      checkOutput("glitch_data", 32'(bus.rx_data), 32'(exp_data));
      runFrame("after_glitch_9E", 8'h9E, 1'b1, 2);

      applyStimulus(8'hC6, 1'b1, 0, 5 * DIV + HALF);
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      checkOutput("midreset_valid", 32'(bus.rx_valid), 32'd0);
      checkOutput("midreset_data", 32'(bus.rx_data), 32'd0);
      checkOutput("midreset_ferr", 32'(bus.frame_err), 32'd0);
      checkOutput("midreset_ovr", 32'(bus.overrun), 32'd0);
      seen = 0;
      for (int i = 0; i < 10 * DIV; i++) begin
         @(posedge clk);
         #1;
         if (bus.rx_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) seen++;
      end
      checkOutput("midreset_quiet", seen, 32'd0);
      runFrame("after_reset_3C", 8'h3C, 1'b1, 0);

      for (int i = 0; i < 3; i++) begin
         logic [7:0] rb;
         int         rm;
         rb = 8'($urandom);
         rm = int'($urandom_range(0, 2));
         runFrame("random", rb, 1'b1, rm);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-oriented UART receiver for the priRV32 SoC, the receive counterpart to the core's serial output path. It deserialises 8N1 frames from the asynchronous `rx` pin at the rate set by `Clock`/`Baud`. Received bytes go into a one-entry holding register, which is read through a valid/ready handshake. It flags framing errors and overruns. It sits between the board RX pin and the core's peripheral bus.

## Interface
- `Clock`, default 50: system clock frequency in MHz.
- `Baud`, default 115200: line rate in bit/s.
- Derived constant DIV = Clock*1000000/Baud, integer-truncated. Default DIV = 434.
- Derived constant HALF = DIV/2, truncated. Default HALF = 217.

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `rx`  input  1  asynchronous serial input; idles high.
- `rx_data`  output  8  received byte, valid while `rx_valid`=1.
- `rx_valid`  output  1  holding register full.
- `rx_ready`  input  1  consumer accepts byte when `rx_valid`&`rx_ready`.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun`  output  1  one-cycle pulse: a byte was dropped because the holding register was full.

## Operation
**Synchroniser**
- `rx` passes through two flops to produce `rx_s`.
- Both flops reset to 1.

**State machine:** IDLE, START, DATA, STOP. A bit counter (0..DIV-1) and an index counter (0..7) drive it.

- **IDLE:** when `rx_s`=0, go to START and clear the bit counter.
- **START:** when the bit counter = HALF-1, sample `rx_s`.
  - 1: false start; return to IDLE with no output.
  - 0: go to DATA; clear the bit counter and the index counter.
- **DATA:** when the bit counter = DIV-1, sample `rx_s` into the shift register, LSB first.
  - Then clear the bit counter and increment the index counter.
  - After index 7 is sampled, go to STOP.
- **STOP:** when the bit counter = DIV-1, sample `rx_s`, then go to IDLE.
  - Returning to IDLE at mid-stop-bit allows back-to-back frames.
  - Sampled 0: `frame_err` pulses; the byte is discarded and no handshake activity occurs.
  - Sampled 1: the byte is "complete"; see the handshake rules below.

**Holding register and handshake**
- If `rx_valid`=0 at completion: load `rx_data` and set `rx_valid`.
- If `rx_valid`=1 and `rx_ready`=1 in the completion cycle: the old byte is consumed and the new byte is loaded. `rx_valid` stays 1.
- If `rx_valid`=1 and `rx_ready`=0 in the completion cycle: the new byte is dropped, `overrun` pulses, and `rx_data` and `rx_valid` are unchanged.
- Otherwise, `rx_valid`&`rx_ready` clears `rx_valid` on the next edge.
- `rx_data` holds its last value after consumption.
- `rx_ready` has no effect while `rx_valid`=0.

**Reset**
- All outputs go to 0, the FSM goes to IDLE, and the counters clear.
- Reset applies in any state, including mid-frame. A partially received frame is abandoned and produces no output.
- After reset, a line already low is treated as a start condition. A glitch shorter than HALF cycles is rejected by the START check.

## Timing
- Let T0 be the first cycle in which `rx_s`=0 while in IDLE. `rx_s` lags `rx` by 2 cycles.
- Start sample at T0+HALF.
- Data bit k sampled at T0+HALF+(k+1)*DIV, for k = 0..7.
- Stop sample at T0+HALF+9*DIV.
- `rx_valid`, `frame_err` or `overrun` is registered visible at T0+HALF+9*DIV+1. Default: T0+4124.
- `frame_err` and `overrun` are exactly one cycle wide.
- `rx_valid` falls one cycle after the accepting handshake edge.
- A new frame's T0 can be as early as 1 cycle after the stop sample.
- No combinational path from `rx_ready` to any output.

## Test plan
1. **Single byte:** reset, then drive 0x55 8N1 at 434 cycles/bit with `rx_ready`=0. Expect `rx_valid`=1 and `rx_data`=0x55 at T0+4124, held until `rx_ready` pulses; `rx_valid`=0 the cycle after.
2. **Back-to-back:** drive 0xA3 then 0x0F with a 1-bit stop and `rx_ready` held at 1. Expect two completions, `rx_data` 0xA3 then 0x0F, and no `overrun`.
3. **Overrun:** send 0x12, then 0x34 with `rx_ready`=0. Expect `overrun` to pulse 1 cycle at the second completion, with `rx_data`=0x12 retained. Also send a byte that completes in the same cycle as `rx_ready`=1: expect no overrun, the new byte loaded, and `rx_valid` to stay 1.
4. **Framing error:** send 0xFF with the stop bit driven low. Expect `frame_err` for 1 cycle at T0+4124 and no change to `rx_valid` or `rx_data`. A following valid 0x81 must be received correctly.
5. **Glitch rejection:** hold `rx` low for 100 cycles, then high. Expect no output, and the FSM back in IDLE after the START sample.
6. **Reset mid-frame:** assert `rst` for 1 cycle during data bit 4 of 0xC6. Expect all outputs 0, no completion for that frame, and a subsequent 0x3C received correctly.
